// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift/add-subtract datapath
// sequenced by a small FSM that stalls F/D/E until the result is registered.
module muldiv_sequencer #(
  parameter int XLEN      = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic            FlushE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            StallMD,
  output logic            BusyMD,
  output logic            DoneMD,
  output logic [XLEN-1:0] ResultMD,
  output logic [4:0]      RdMD
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     opA_q, opB_q;
  logic [2:0]          funct_q;
  logic [4:0]          rdPend_q, rd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     result_q;
  logic                done_q;
  logic                negRes_q;
  logic                divZero_q;

  logic                isDiv, aSigned, bSigned, signA, signB;
  logic [XLEN-1:0]     aMag_d, bMag_d;
  logic                negRes_d, divZero_d;
  logic [CW-1:0]       bitIdx;
  logic [2*XLEN-1:0]   mulAdd, mulNext, acc_d;
  logic [XLEN:0]       remShift, remDiff;
  logic                qBit;
  logic [XLEN-1:0]     remNext;
  logic [2*XLEN-1:0]   prodSigned;
  logic [XLEN-1:0]     quoMag, remMag, result_d;

  // Operand decode and magnitude/sign preparation, consumed in PREP.
  always_comb begin
    isDiv     = funct_q[2];
    aSigned   = isDiv ? ~funct_q[0] : (funct_q[1:0] == 2'b01 || funct_q[1:0] == 2'b10);
    bSigned   = isDiv ? ~funct_q[0] : (funct_q[1:0] == 2'b01);
    signA     = aSigned & opA_q[XLEN-1];
    signB     = bSigned & opB_q[XLEN-1];
    aMag_d    = signA ? -opA_q : opA_q;
    bMag_d    = signB ? -opB_q : opB_q;
    negRes_d  = (isDiv && funct_q[1]) ? signA : (signA ^ signB);
    divZero_d = isDiv && (opB_q == '0);
  end

  // One radix-2 step: MSB-first shift-add for multiply, restoring step for divide.
  always_comb begin
    bitIdx   = CW'(XLEN-1) - cnt_q;
    mulAdd   = opB_q[bitIdx] ? {{XLEN{1'b0}}, opA_q} : '0;
    mulNext  = {acc_q[2*XLEN-2:0], 1'b0} + mulAdd;
    remShift = {acc_q[2*XLEN-1:XLEN], opA_q[bitIdx]};
    remDiff  = remShift - {1'b0, opB_q};
    qBit     = ~remDiff[XLEN];
    remNext  = qBit ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
    acc_d    = isDiv ? {remNext, acc_q[XLEN-2:0], qBit} : mulNext;
  end

  // Sign fix-up and result word selection; divide-by-zero overrides the datapath.
  always_comb begin
    prodSigned = negRes_q ? -acc_q : acc_q;
    quoMag     = acc_q[XLEN-1:0];
    remMag     = divZero_q ? opA_q : acc_q[2*XLEN-1:XLEN];
    result_d   = '0;
    case (funct_q)
      3'b000:                 result_d = prodSigned[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_d = prodSigned[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_d = divZero_q ? '1 : (negRes_q ? -quoMag : quoMag);
      default:                result_d = negRes_q ? -remMag : remMag;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      funct_q   <= '0;
      rdPend_q  <= '0;
      rd_q      <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      negRes_q  <= 1'b0;
      divZero_q <= 1'b0;
    end else if (FlushE) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (StartE) begin
            opA_q    <= SrcAE;
            opB_q    <= SrcBE;
            funct_q  <= Funct3E;
            rdPend_q <= RdE;
            state_q  <= PREP;
          end
        end
        PREP: begin
          opA_q     <= aMag_d;
          opB_q     <= bMag_d;
          negRes_q  <= negRes_d;
          divZero_q <= divZero_d;
          acc_q     <= '0;
          cnt_q     <= '0;
          state_q   <= (divZero_d && ZERO_FAST) ? FIX : CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= result_d;
          rd_q     <= rdPend_q;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign StallMD  = (state_q == IDLE && StartE && !FlushE) ||
                    state_q == PREP || state_q == CALC || state_q == FIX;
  assign BusyMD   = (state_q != IDLE);
  assign DoneMD   = done_q;
  assign ResultMD = result_q;
  assign RdMD     = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected {result, rd};
// a negedge monitor pops and compares whenever DoneMD is presented.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        StartE, FlushE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        StallMD, BusyMD, DoneMD;
  logic [31:0] ResultMD;
  logic [4:0]  RdMD;

  int checks = 0;
  int errors = 0;
  logic [36:0] expQ[$];
  logic [31:0] lastResult;
  logic [4:0]  lastRd;

  muldiv_sequencer #(.XLEN(32), .ZERO_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .FlushE(FlushE), .Funct3E(Funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .StallMD(StallMD), .BusyMD(BusyMD),
    .DoneMD(DoneMD), .ResultMD(ResultMD), .RdMD(RdMD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DoneMD pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && DoneMD) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got DoneMD=1 expected no pending op");
      end else begin
        logic [36:0] e;
        e = expQ.pop_front();
        checkOutput("result", {32'h0, ResultMD}, {32'h0, e[36:5]});
        checkOutput("rd", {59'h0, RdMD}, {59'h0, e[4:0]});
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expRes,
                               input int expLat, input bit holdStart);
    int k;
    bit seen;
    int stallLow;
    @(negedge clk);
    Funct3E = f; SrcAE = a; SrcBE = b; RdE = rd; StartE = 1'b1;
    expQ.push_back({expRes, rd});
    #1 checkOutput("stall_at_start", {63'h0, StallMD}, 64'h1);
    @(posedge clk);
    #1;
    if (!holdStart) StartE = 1'b0;
    // Scramble E-stage inputs: the unit must use its latched copies.
    SrcAE = 32'hDEADBEEF; SrcBE = 32'h12345678; Funct3E = ~f; RdE = ~rd;
    seen = 1'b0;
    stallLow = 0;
    k = 0;
    while (!seen && k < 80) begin
      if (!StallMD) stallLow++;
      @(posedge clk);
      #1;
      k++;
      if (DoneMD) begin
        seen = 1'b1;
        checkOutput("done_latency", 64'(k), 64'(expLat));
        checkOutput("stall_in_done", {63'h0, StallMD}, 64'h0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no DoneMD expected one within 80 cycles");
    end
    checkOutput("stall_high_until_done", 64'(stallLow), 64'h0);
    @(posedge clk);
    #1;
    StartE = 1'b0;
    checkOutput("done_single_pulse", {63'h0, DoneMD}, 64'h0);
    checkOutput("idle_after_done", {63'h0, BusyMD}, 64'h0);
    if (holdStart) begin
      @(posedge clk);
      #1 checkOutput("no_restart_from_done", {63'h0, BusyMD}, 64'h0);
    end
    lastResult = expRes;
    lastRd = rd;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_stall"}, {63'h0, StallMD}, 64'h0);
    checkOutput({tag, "_busy"}, {63'h0, BusyMD}, 64'h0);
    checkOutput({tag, "_done"}, {63'h0, DoneMD}, 64'h0);
    checkOutput({tag, "_result"}, {32'h0, ResultMD}, 64'h0);
    checkOutput({tag, "_rd"}, {59'h0, RdMD}, 64'h0);
  endtask

  initial begin
    rst = 1'b1; StartE = 1'b0; FlushE = 1'b0; Funct3E = '0;
    SrcAE = '0; SrcBE = '0; RdE = '0;
    lastResult = '0; lastRd = '0;
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Flush and start together in IDLE: flush wins.
    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; Funct3E = 3'b000; SrcAE = 32'd3; SrcBE = 32'd4; RdE = 5'd1;
    @(posedge clk);
    #1 checkOutput("flush_beats_start", {63'h0, BusyMD}, 64'h0);
    StartE = 1'b0; FlushE = 1'b0;

    applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34, 1'b0);
    applyStimulus(3'b001, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 34, 1'b0);
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 34, 1'b0);
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFF, 34, 1'b0);
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 34, 1'b0);
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 34, 1'b0);
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 34, 1'b0);
    applyStimulus(3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 34, 1'b0);
    applyStimulus(3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFFFFFF, 2, 1'b0);
    applyStimulus(3'b110, 32'd5, 32'd0, 5'd15, 32'd5, 2, 1'b0);
    applyStimulus(3'b100, 32'hFFFFFFFB, 32'd0, 5'd16, 32'hFFFFFFFF, 2, 1'b0);
    applyStimulus(3'b110, 32'hFFFFFFFB, 32'd0, 5'd17, 32'hFFFFFFFB, 2, 1'b0);
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 34, 1'b0);
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 34, 1'b0);

    // Flush while the counter reads 10 (after edge 11); no DoneMD may follow.
    @(negedge clk);
    Funct3E = 3'b000; SrcAE = 32'd9; SrcBE = 32'd9; RdE = 5'd3; StartE = 1'b1;
    @(posedge clk);
    #1 StartE = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    FlushE = 1'b1;
    @(posedge clk);
    #1 FlushE = 1'b0;
    checkOutput("flush_busy", {63'h0, BusyMD}, 64'h0);
    checkOutput("flush_stall", {63'h0, StallMD}, 64'h0);
    checkOutput("flush_done", {63'h0, DoneMD}, 64'h0);
    checkOutput("flush_keeps_result", {32'h0, ResultMD}, {32'h0, lastResult});
    checkOutput("flush_keeps_rd", {59'h0, RdMD}, {59'h0, lastRd});
    repeat (40) @(posedge clk);
    applyStimulus(3'b011, 32'd6, 32'd7, 5'd9, 32'd0, 34, 1'b0);

    // Reset pulsed mid-CALC clears everything at once.
    @(negedge clk);
    Funct3E = 3'b101; SrcAE = 32'd50; SrcBE = 32'd3; RdE = 5'd21; StartE = 1'b1;
    @(posedge clk);
    #1 StartE = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkAllZero("midcalc_reset");
    @(negedge clk);
    rst = 1'b0;

    // StartE held through DONE, then back-to-back ops.
    applyStimulus(3'b000, 32'd12, 32'd12, 5'd22, 32'd144, 34, 1'b1);
    applyStimulus(3'b101, 32'd144, 32'd12, 5'd23, 32'd12, 34, 1'b0);
    applyStimulus(3'b111, 32'd145, 32'd12, 5'd24, 32'd1, 34, 1'b0);

    repeat (4) @(posedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
